// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 8-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Pointer advance past the winner; 3-bit natural wrap takes 7 back to 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] winner);
        return SEL_W'(winner + SEL_W'(1));
    endfunction

endpackage : mux_arb_pkg

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set req bit searching from ptr upward, mod 8.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = SEL_W'(ptr + SEL_W'(i));
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    assign any    = |req;
    assign onehot = any ? (N_REQ'(1) << idx) : '0;

endmodule : rr_pick8

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 data mux; registered output with valid/ready.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] Y,
    output logic [SEL_W-1:0] Y_sel,
    output logic             Y_valid,
    input  logic             Y_ready
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [WIDTH-1:0] mux_data;
    logic             accept;
    logic             slot_free;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Shared 8:1 select path driven by the picker's index.
    always_comb begin
        mux_data = '0;
        case (pick_idx)
            3'd0:    mux_data = D0;
            3'd1:    mux_data = D1;
            3'd2:    mux_data = D2;
            3'd3:    mux_data = D3;
            3'd4:    mux_data = D4;
            3'd5:    mux_data = D5;
            3'd6:    mux_data = D6;
            3'd7:    mux_data = D7;
            default: mux_data = '0;
        endcase
    end

    // Output slot can take a new word when empty or when it is draining this cycle.
    assign slot_free = (state_q == ARB_IDLE) || (valid_q && Y_ready);
    assign accept    = slot_free && pick_any && !rst;
    assign gnt       = pick_onehot & {N_REQ{accept}};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (accept) begin
            y_d     = mux_data;
            sel_d   = pick_idx;
            valid_d = 1'b1;
            ptr_d   = next_ptr(pick_idx);
            state_d = ARB_HOLD;
        end else if ((state_q == ARB_HOLD) && Y_ready) begin
            // Drained with nobody waiting: keep Y/Y_sel, just drop valid.
            valid_d = 1'b0;
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign Y       = y_q;
    assign Y_sel   = sel_q;
    assign Y_valid = valid_q;

endmodule : mux8_rr_arbiter

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0] gnt;
    logic [3:0] y;
    logic [2:0] y_sel;
    logic       y_valid;
    logic       y_ready;

    int checks = 0;
    int errors = 0;

    mux8_rr_arbiter #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .D0      (d0),
        .D1      (d1),
        .D2      (d2),
        .D3      (d3),
        .D4      (d4),
        .D5      (d5),
        .D6      (d6),
        .D7      (d7),
        .gnt     (gnt),
        .Y       (y),
        .Y_sel   (y_sel),
        .Y_valid (y_valid),
        .Y_ready (y_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d_index();
        d0 = 4'd0; d1 = 4'd1; d2 = 4'd2; d3 = 4'd3;
        d4 = 4'd4; d5 = 4'd5; d6 = 4'd6; d7 = 4'd7;
    endtask

    logic [7:0] exp_g;

    initial begin
        set_d_index();
        rst     = 1'b1;
        req     = 8'hFF;
        y_ready = 1'b1;

        // 1. Reset holds gnt low even with every requester active.
        #1;
        check("rst_gnt0", 32'(gnt), 32'h00);
        tick();
        check("rst_gnt1", 32'(gnt), 32'h00);
        check("rst_y", 32'(y), 32'h0);
        check("rst_sel", 32'(y_sel), 32'h0);
        check("rst_valid", 32'(y_valid), 32'h0);
        tick();
        check("rst_gnt2", 32'(gnt), 32'h00);
        check("rst_valid2", 32'(y_valid), 32'h0);
        rst = 1'b0;
        req = 8'h00;
        tick();
        check("idle_valid", 32'(y_valid), 32'h0);

        // 2. Single request from IDLE, then drop.
        d2  = 4'hA;
        req = 8'b0000_0100;
        #1;
        check("single_gnt", 32'(gnt), 32'h04);
        tick();
        check("single_y", 32'(y), 32'hA);
        check("single_sel", 32'(y_sel), 32'h2);
        check("single_valid", 32'(y_valid), 32'h1);
        req = 8'h00;
        #1;
        check("drop_gnt", 32'(gnt), 32'h00);
        tick();
        check("drop_valid", 32'(y_valid), 32'h0);
        check("drop_y_keep", 32'(y), 32'hA);
        check("drop_sel_keep", 32'(y_sel), 32'h2);
        set_d_index();

        // Return pointer to 0 before the round-robin walk.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 3. Round robin with all requesters, one transfer per cycle.
        req     = 8'hFF;
        y_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            #1;
            check("rr_gnt", 32'(gnt), 32'(exp_g));
            tick();
            check("rr_sel", 32'(y_sel), 32'(k % 8));
            check("rr_y", 32'(y), 32'(k % 8));
            check("rr_valid", 32'(y_valid), 32'h1);
        end

        // 4. Advance to Y=3, then backpressure for five cycles.
        for (int k = 1; k < 4; k++) begin
            exp_g = 8'h01 << k;
            #1;
            check("adv_gnt", 32'(gnt), 32'(exp_g));
            tick();
            check("adv_sel", 32'(y_sel), 32'(k));
        end
        y_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_gnt", 32'(gnt), 32'h00);
            tick();
            check("bp_y", 32'(y), 32'h3);
            check("bp_sel", 32'(y_sel), 32'h3);
            check("bp_valid", 32'(y_valid), 32'h1);
        end
        y_ready = 1'b1;
        #1;
        check("bp_release_gnt", 32'(gnt), 32'h10);
        tick();
        check("bp_release_sel", 32'(y_sel), 32'h4);
        check("bp_release_y", 32'(y), 32'h4);

        // 5. Wrap-around: grant 5, 6, then pointer at 7 with only 0 and 6 requesting.
        #1;
        check("wrap_gnt5", 32'(gnt), 32'h20);
        tick();
        #1;
        check("wrap_gnt6", 32'(gnt), 32'h40);
        tick();
        check("wrap_sel6", 32'(y_sel), 32'h6);
        req = 8'b0100_0001;
        #1;
        check("wrap_gnt0", 32'(gnt), 32'h01);
        tick();
        check("wrap_sel0", 32'(y_sel), 32'h0);
        check("wrap_y0", 32'(y), 32'h0);
        #1;
        check("wrap_gnt6b", 32'(gnt), 32'h40);
        tick();
        check("wrap_sel6b", 32'(y_sel), 32'h6);
        check("wrap_y6b", 32'(y), 32'h6);

        // 6. Reset pulse while holding a stalled transfer.
        y_ready = 1'b0;
        rst     = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h00);
        tick();
        check("mid_rst_valid", 32'(y_valid), 32'h0);
        check("mid_rst_y", 32'(y), 32'h0);
        check("mid_rst_sel", 32'(y_sel), 32'h0);
        rst     = 1'b0;
        d0      = 4'h9;
        req     = 8'b1000_0001;
        y_ready = 1'b1;
        #1;
        check("post_rst_gnt", 32'(gnt), 32'h01);
        tick();
        check("post_rst_sel", 32'(y_sel), 32'h0);
        check("post_rst_y", 32'(y), 32'h9);
        check("post_rst_valid", 32'(y_valid), 32'h1);
        req = 8'h00;
        tick();
        check("final_valid", 32'(y_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux8_rr_arbiter

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares one 8:1 WIDTH-bit select path among eight requesters. Each requester presents data on its own D input and raises req. The block picks one requester, drives the mux select, and captures the selected word into an output register. It presents that word downstream with a valid/ready handshake. It sits between the eight producer blocks and a single consumer of the shared mux output.

Parameters:
WIDTH, 4, data width of each D input and of Y

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  8  req[i]=1: requester i has valid data on Di
D0..D7  input  WIDTH each  requester data words
gnt  output  8  one-hot accept strobe, combinational; gnt[i]=1 in the cycle Di is captured
Y  output  WIDTH  registered selected data
Y_sel  output  3  registered index of the requester that produced Y
Y_valid  output  1  Y/Y_sel hold a transfer
Y_ready  input  1  consumer accepts Y this cycle when Y_valid=1

Behaviour:
- Reset (rst=1 at clk edge): Y=0, Y_sel=0, Y_valid=0, ptr=0, state=ARB_IDLE. gnt is forced to 0 while rst=1.
- ptr (3-bit) is the highest-priority index. The search order is ptr, ptr+1, … ptr+7, all mod 8.
- accept = (state==ARB_IDLE || (Y_valid && Y_ready)) && |req && !rst.
- On accept:
  - w = first set req bit in search order.
  - gnt = 1<<w in that cycle.
  - At the edge: Y<=Dw, Y_sel<=w, Y_valid<=1, ptr<=w+1 (3-bit natural wrap: 7 -> 0), state<=ARB_HOLD.
- Otherwise gnt=0.
- Requester handshake:
  - Di is sampled only in the gnt[i] cycle.
  - The requester drops req or presents its next word on the cycle after gnt[i].
  - Holding req high means another request.
- ARB_HOLD:
  - Y, Y_sel and Y_valid are stable while Y_ready=0. No accept and gnt=0.
  - On Y_ready=1 with |req=1: back-to-back accept in the same cycle. Y is overwritten and Y_valid stays 1, giving one transfer per cycle.
  - On Y_ready=1 with req=0: Y_valid<=0, state<=ARB_IDLE. Y and Y_sel keep their last values.
- ARB_IDLE: Y_valid=0. Accept as soon as |req=1. Latency from req to Y_valid is 1 cycle.
- Fairness: a requester that holds req continuously is granted within 8 accepts.
- Y_ready is ignored while Y_valid=0.
- Reset mid-operation: the pending transfer is discarded (Y_valid<=0) and ptr returns to 0. No gnt is asserted in the reset cycle.
- req changes while in HOLD with Y_ready=0 have no effect until the next accept cycle. Arbitration uses req in the accept cycle only.

Decomposition:
- Package mux_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_t
  - localparam N_REQ=8
  - localparam SEL_W=3
- Sub-module rr_pick8: combinational rotating priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0], onehot[7:0].
- The top level holds the FSM, ptr, the output registers and the 8:1 case select on idx.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=8'hFF, Y_ready=1 -> gnt=0 throughout; afterwards Y=0, Y_sel=0, Y_valid=0.
2. Single request: req=8'b0000_0100, D2=4'hA, Y_ready=1 from IDLE -> gnt=8'h04 that cycle; next cycle Y=4'hA, Y_sel=2, Y_valid=1. Then drop req -> Y_valid=0 the following cycle.
3. Round robin: req=8'hFF held, Di=i, Y_ready=1 -> gnt walks 01,02,04,…,80,01 one per cycle. Y_sel sequence is 0,1,…,7,0 and Y equals Y_sel each cycle.
4. Backpressure: Y_valid=1, Y=4'h3, Y_ready=0 for 5 cycles with req=8'hFF -> Y, Y_sel and Y_valid are unchanged and gnt=0. On the first Y_ready=1 cycle exactly one gnt fires, at index Y_sel+1.
5. Wrap-around: after a grant to 6 (ptr=7), req=8'b0100_0001 -> grant 0 (not 6), then ptr=1. Next accept with the same req -> grant 6.
6. Reset mid-transfer: in HOLD with Y_valid=1, Y_ready=0, pulse rst for 1 cycle -> Y_valid=0 and ptr=0. With req=8'b1000_0001 the next accept grants 0.
